fatorador_engine_param: RTL and testbench
=========================================

// Module: fatorador_engine_param
// PURPOSE
// - Parametrised sequential prime-factorisation engine; successor to the fixed 16-bit/4-slot engine behind the board top.
// - Factors an unsigned WIDTH-bit value by trial division over a multi-cycle divider.
// - Returns up to NUM_FACTORS prime factors (ascending, with multiplicity) over a 4-phase req/ack handshake.
// - Optional auto mode re-factors whenever the input changes; feeds bin_to_bcd/hex_to_7seg display chains.
// PARAMETERS
// - WIDTH        16  bit width of value and working remainder n
// - NUM_FACTORS   4  result slots; more factors -> overflow
// - FACTOR_W      8  bits per result slot; larger factors stored saturated
// - AUTO          0  1: in DONE, a change of value restarts factorisation without req toggling
// PORTS
// - CLOCK_50  in   1                    sole clock, rising edge
// - rst_n     in   1                    asynchronous, active-low reset
// - req       in   1                    request, level; 4-phase with ack
// - value     in   WIDTH                number to factorise; sampled on accept only
// - ack       out  1                    results valid; held until req low (AUTO=0)
// - busy      out  1                    high in LOAD/DIV/CHECK
// - factors   out  NUM_FACTORS*FACTOR_W slot k at [k*FACTOR_W +: FACTOR_W], slot 0 smallest; unused = 0
// - count     out  $clog2(NUM_FACTORS+1) number of valid slots
// - overflow  out  1                    >NUM_FACTORS factors, or a factor > 2^FACTOR_W-1
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; ack=0, busy=0, factors=0, count=0, overflow=0; divider idle.
// - States: IDLE, LOAD, DIV, CHECK, DONE.
// - IDLE: req=1 -> latch value into n and v_lat, d=2, clear factors/count/overflow -> LOAD.
// - LOAD: n<2 -> DONE with count=0 (value 0 or 1); else start divider n/d -> DIV.
// - DIV: wait divider done (WIDTH+1 cycles after start) -> CHECK.
// - CHECK: rem==0 -> record d (slot[count], count++), n<=quot; else d<=d+1 (d=2 -> 3, then odd only: d+=2).
//   Then: n==1 -> DONE; d*d>n (2*WIDTH-bit compare) -> record n as final prime, DONE; else start divider -> DIV.
// - Recording when count==NUM_FACTORS: drop factor, set overflow, continue dividing so n reduces correctly.
// - Recorded factor > 2^FACTOR_W-1: slot = all ones, overflow=1.
// - DONE: ack=1. AUTO=0: req low -> ack=0, IDLE (results kept until next accept).
//   AUTO=1: value!=v_lat -> ack=0, reload as in IDLE; req ignored except for abort below.
// - Abort: req=0 while busy (AUTO=0 only) -> IDLE next cycle, factors/count/overflow cleared, ack never pulses.
// - req held high after DONE+ack drop is impossible (ack drops only on req low); new req needs req low >=1 cycle.
// - value changes while busy are ignored; v_lat is used throughout.
// - Outputs registered; factors/count update in CHECK and are stable whenever ack=1.
// - Latency: accept->ack = 2 cycles for n<2; otherwise sum over trials of (WIDTH+3) cycles.
// STRUCTURE
// - Shared package fatorador_pkg: state encoding constants (IDLE..DONE), slot-index helper width function.
// - Sub-module seq_divmod #(WIDTH): restoring divider; start, dividend, divisor -> done pulse, quot, rem; rst_n async.
// - Engine top: FSM, n/d/v_lat registers, slot array, d*d compare; no combinational divide.
// TESTING
// - value=12, req 1 -> ack; factors slots {2,2,3,0}, count=3, overflow=0; req 0 -> ack 0 next cycle.
// - value=97 (prime) -> slot0=97, count=1; value=1 -> count=0, ack exactly 2 cycles after accept.
// - value=65536 -> slots {2,2,2,2}, count=4, overflow=1; value=2*257 -> slot1=255, overflow=1.
// - Abort: value=65521, drop req 5 cycles into DIV -> IDLE, ack stays 0, outputs 0; re-req value=6 -> {2,3}.
// - rst_n low mid-DIV -> all outputs 0 immediately (async); after release, value=30 -> {2,3,5}, count=3.
// - AUTO=1: value 10 -> {2,5}; change value to 9 in DONE -> ack drops, then {3,3} with ack=1.

Source files
------------

// File: rtl/fatorador_pkg.sv
// Shared definitions for the prime-factorisation engine.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package fatorador_pkg;

    // Engine control states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIV   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Width of a counter able to hold 0..slots inclusive.
    function automatic int cnt_width(input int slots);
        return (slots < 1) ? 1 : $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/seq_divmod.sv
// Restoring divider: one quotient bit per cycle, quot/rem held until the next start.
// Latency: done pulses WIDTH+1 cycles after start is sampled.
// Backpressure: none; a new start restarts the divider and discards any run in progress.
module seq_divmod #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             done_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_trial;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        r_shift = {rem_q, quot_q[WIDTH-1]};
        r_trial = r_shift - {1'b0, dvs_q};
    end

    // Iterate WIDTH times, then emit a one-cycle done pulse.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                quot_q <= dividend_i;
                rem_q  <= '0;
                dvs_q  <= divisor_i;
                cnt_q  <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (r_trial[WIDTH]) begin
                        // Subtract went negative: keep the shifted remainder.
                        rem_q  <= r_shift[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_q  <= r_trial[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
                    end
                end
            end
        end
    end

    assign done_o = done_q;
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/fatorador_engine_param.sv
// Trial-division prime factoriser returning up to NUM_FACTORS ascending factors.
// Latency: accept->ack = 2 + trials*(WIDTH+3) cycles.
// Backpressure: 4-phase req/ack; ack held until req drops (AUTO=0), req low while busy aborts.
module fatorador_engine_param
    import fatorador_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_FACTORS = 4,
    parameter int FACTOR_W    = 8,
    parameter int AUTO        = 0
) (
    input  logic                              CLOCK_50,
    input  logic                              rst_n,
    input  logic                              req,
    input  logic [WIDTH-1:0]                  value,
    output logic                              ack,
    output logic                              busy,
    output logic [NUM_FACTORS*FACTOR_W-1:0]   factors,
    output logic [cnt_width(NUM_FACTORS)-1:0] count,
    output logic                              overflow
);

    localparam int CW = cnt_width(NUM_FACTORS);
    localparam int DW = 2 * WIDTH;

    state_e                                state_q, state_d;
    logic [WIDTH-1:0]                      n_q, n_d;
    logic [WIDTH-1:0]                      d_q, d_d;
    logic [WIDTH-1:0]                      v_lat_q, v_lat_d;
    logic [NUM_FACTORS-1:0][FACTOR_W-1:0]  slots_q, slots_d;
    logic [CW-1:0]                         count_q, count_d;
    logic                                  ovf_q, ovf_d;
    logic                                  ack_q, ack_d;
    logic                                  busy_q, busy_d;

    logic                                  div_start;
    logic                                  div_done;
    logic [WIDTH-1:0]                      div_quot;
    logic [WIDTH-1:0]                      div_rem;

    logic                                  accept;
    logic                                  abort;
    logic [1:0]                            rec_en;
    logic [1:0][WIDTH-1:0]                 rec_val;
    logic [DW-1:0]                         dd;

    // Divider always works on the next-state n/d so a new trial can start straight out of CHECK.
    seq_divmod #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk_i      (CLOCK_50),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (n_d),
        .divisor_i  (d_d),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Next-state, trial bookkeeping and result-slot recording.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        d_d       = d_q;
        v_lat_d   = v_lat_q;
        slots_d   = slots_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        ack_d     = ack_q;
        busy_d    = 1'b0;
        div_start = 1'b0;
        accept    = 1'b0;
        abort     = 1'b0;
        rec_en    = '0;
        rec_val   = '0;
        dd        = '0;

        case (state_q)
            S_IDLE: begin
                accept = req;
            end
            S_LOAD: begin
                if (AUTO == 0 && !req) begin
                    abort = 1'b1;
                end else if (n_q < WIDTH'(2)) begin
                    state_d = S_DONE;
                end else begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                if (AUTO == 0 && !req) begin
                    abort = 1'b1;
                end else if (div_done) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (AUTO == 0 && !req) begin
                    abort = 1'b1;
                end else begin
                    if (div_rem == '0) begin
                        rec_en[0]  = 1'b1;
                        rec_val[0] = d_q;
                        n_d        = div_quot;
                    end else begin
                        // After 2 only odd candidates can be prime.
                        d_d = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
                    end
                    dd = DW'(d_d) * DW'(d_d);
                    if (n_d == WIDTH'(1)) begin
                        state_d = S_DONE;
                    end else if (dd > DW'(n_d)) begin
                        // No divisor up to sqrt(n) is left, so n itself is prime.
                        rec_en[1]  = 1'b1;
                        rec_val[1] = n_d;
                        state_d    = S_DONE;
                    end else begin
                        div_start = 1'b1;
                        state_d   = S_DIV;
                    end
                end
            end
            S_DONE: begin
                if (AUTO == 0) begin
                    if (!req) begin
                        ack_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        ack_d = 1'b1;
                    end
                end else if (value != v_lat_q) begin
                    ack_d  = 1'b0;
                    accept = 1'b1;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            slots_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            ack_d   = 1'b0;
        end

        if (accept) begin
            state_d = S_LOAD;
            v_lat_d = value;
            n_d     = value;
            d_d     = WIDTH'(2);
            slots_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end

        // A single CHECK can record both the divisor and the final prime remainder.
        for (int r = 0; r < 2; r++) begin
            if (rec_en[r]) begin
                if (count_d == CW'(NUM_FACTORS)) begin
                    // Slots full: drop the factor but keep reducing n.
                    ovf_d = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_FACTORS; k++) begin
                        if (count_d == CW'(k)) begin
                            if ((rec_val[r] >> FACTOR_W) != '0) begin
                                slots_d[k] = '1;
                            end else begin
                                slots_d[k] = FACTOR_W'(rec_val[r]);
                            end
                        end
                    end
                    if ((rec_val[r] >> FACTOR_W) != '0) begin
                        ovf_d = 1'b1;
                    end
                    count_d = count_d + CW'(1);
                end
            end
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_DIV) || (state_d == S_CHECK);
    end

    // State, working registers and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            d_q     <= '0;
            v_lat_q <= '0;
            slots_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            v_lat_q <= v_lat_d;
            slots_q <= slots_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign factors  = slots_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fatorador_engine_param.sv
// Bench for the factorisation engine: reference factoriser, directed corner cases, random values.
// Latency: n/a.
// Backpressure: drives a 4-phase req/ack requester.
module tb_fatorador_engine_param;

    logic        clk;
    logic        rst_n;
    logic        req,  req_a;
    logic [15:0] value;
    logic [16:0] value_a;
    logic        ack,  ack_a;
    logic        busy, busy_a;
    logic [31:0] factors, factors_a;
    logic [2:0]  count, count_a;
    logic        overflow, overflow_a;

    logic [31:0] exp_f,  exp_fa;
    int          exp_c,  exp_ca;
    logic        exp_o,  exp_oa;

    int errors = 0;
    int checks = 0;

    fatorador_engine_param #(
        .WIDTH(16), .NUM_FACTORS(4), .FACTOR_W(8), .AUTO(0)
    ) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .req      (req),
        .value    (value),
        .ack      (ack),
        .busy     (busy),
        .factors  (factors),
        .count    (count),
        .overflow (overflow)
    );

    fatorador_engine_param #(
        .WIDTH(17), .NUM_FACTORS(4), .FACTOR_W(8), .AUTO(1)
    ) dut_a (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .req      (req_a),
        .value    (value_a),
        .ack      (ack_a),
        .busy     (busy_a),
        .factors  (factors_a),
        .count    (count_a),
        .overflow (overflow_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain factorisation into an ascending prime list, then the slot/overflow
    // rules; the trial count follows the candidate schedule 2,3,5,7,... stopping once n==1
    // or the next candidate squared exceeds n.
    function automatic void model(input int v, output logic [31:0] f, output int c,
                                  output logic o, output int t);
        int   primes[$];
        int   n;
        int   p;
        int   d;
        logic stop;
        f = '0; c = 0; o = 1'b0; t = 0;
        n = v; p = 2;
        while (n > 1) begin
            if (p * p > n) begin
                primes.push_back(n);
                n = 1;
            end else if (n % p == 0) begin
                primes.push_back(p);
                n = n / p;
            end else begin
                p++;
            end
        end
        foreach (primes[i]) begin
            if (c == 4) begin
                o = 1'b1;
            end else begin
                if (primes[i] > 255) begin
                    f[c*8 +: 8] = 8'hFF;
                    o = 1'b1;
                end else begin
                    f[c*8 +: 8] = 8'(primes[i]);
                end
                c++;
            end
        end
        n = v; d = 2; stop = (v < 2);
        while (!stop) begin
            t++;
            if (n % d == 0) n = n / d;
            else d = (d == 2) ? 3 : d + 2;
            if (n == 1 || d * d > n) stop = 1'b1;
        end
    endfunction

    // Whenever a result is presented it must match the reference.
    always @(negedge clk) begin
        if (rst_n && ack) begin
            chk("ack_factors", 64'(factors), 64'(exp_f));
            chk("ack_count", 64'(count), 64'(exp_c));
            chk("ack_overflow", 64'(overflow), 64'(exp_o));
            chk("ack_busy", 64'(busy), 64'd0);
        end
        if (rst_n && ack_a) begin
            chk("auto_factors", 64'(factors_a), 64'(exp_fa));
            chk("auto_count", 64'(count_a), 64'(exp_ca));
            chk("auto_overflow", 64'(overflow_a), 64'(exp_oa));
        end
    end

    task automatic wait_ack(input bit auto_dut, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (((auto_dut ? ack_a : ack) == 1'b0) && lat < 5000);
    endtask

    task automatic run_txn(input int v, input string tag);
        logic [31:0] f;
        int          c;
        logic        o;
        int          t;
        int          lat;
        model(v, f, c, o, t);
        exp_f = f; exp_c = c; exp_o = o;
        @(negedge clk);
        value = 16'(v);
        req   = 1'b1;
        @(posedge clk);
        #1 value = 16'($urandom);
        wait_ack(1'b0, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(2 + t * 19));
        req = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_ack_drop"}, 64'(ack), 64'd0);
        chk({tag, "_count_kept"}, 64'(count), 64'(c));
    endtask

    task automatic abort_after(input int v, input int cyc, input int cnt_before, input string tag);
        @(negedge clk);
        value = 16'(v);
        req   = 1'b1;
        @(posedge clk);
        repeat (cyc) @(posedge clk);
        #1;
        chk({tag, "_busy_before"}, 64'(busy), 64'd1);
        chk({tag, "_count_before"}, 64'(count), 64'(cnt_before));
        req = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_outputs"}, {29'd0, ack, overflow, count, factors}, 64'd0);
        repeat (30) @(posedge clk);
        #1;
        chk({tag, "_ack_quiet"}, 64'(ack), 64'd0);
    endtask

    task automatic auto_change(input int v, input string tag);
        logic [31:0] f;
        int          c;
        logic        o;
        int          t;
        int          lat;
        value_a = 17'(v);
        @(posedge clk);
        #1;
        chk({tag, "_ack_drop"}, 64'(ack_a), 64'd0);
        chk({tag, "_busy"}, 64'(busy_a), 64'd1);
        model(v, f, c, o, t);
        exp_fa = f; exp_ca = c; exp_oa = o;
        wait_ack(1'b1, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(2 + t * 20));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] f;
        int          c;
        logic        o;
        int          t;
        int          lat;

        rst_n = 1'b0; req = 1'b0; req_a = 1'b0; value = '0; value_a = '0;
        exp_f = '0; exp_c = 0; exp_o = 1'b0; exp_fa = '0; exp_ca = 0; exp_oa = 1'b0;
        #3;
        chk("reset_outputs", {29'd0, ack, busy, overflow, count, factors}, 64'd0);
        chk("reset_outputs_auto", {29'd0, ack_a, busy_a, overflow_a, count_a, factors_a}, 64'd0);

        model(12, f, c, o, t);
        chk("pin12_f", 64'(f), 64'h0003_0202);
        chk("pin12_c", 64'(c), 64'd3);
        chk("pin12_t", 64'(t), 64'd2);
        model(65536, f, c, o, t);
        chk("pin65536_f", 64'(f), 64'h0202_0202);
        chk("pin65536_o", 64'(o), 64'd1);
        chk("pin65536_t", 64'(t), 64'd15);
        model(514, f, c, o, t);
        chk("pin514_f", 64'(f), 64'h0000_FF02);
        chk("pin514_t", 64'(t), 64'd9);
        model(65535, f, c, o, t);
        chk("pin65535_f", 64'(f), 64'hFF11_0503);
        model(1, f, c, o, t);
        chk("pin1_ct", {32'(c), 32'(t)}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_txn(12, "v12");
        run_txn(97, "v97");
        run_txn(1, "v1");
        run_txn(0, "v0");
        run_txn(2, "v2");
        run_txn(514, "v514");
        run_txn(65535, "v65535");
        run_txn(32768, "v32768");

        abort_after(65521, 6, 0, "abort_prime");
        abort_after(32768, 45, 2, "abort_mid");
        run_txn(6, "after_abort");

        // Asynchronous reset in the middle of a factorisation.
        @(negedge clk);
        value = 16'd32768;
        req   = 1'b1;
        @(posedge clk);
        repeat (45) @(posedge clk);
        #1;
        chk("pre_reset_count", 64'(count), 64'd2);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk("async_reset_outputs", {29'd0, ack, busy, overflow, count, factors}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(30, "v30");

        // AUTO mode: a value change in DONE restarts without toggling req.
        model(10, f, c, o, t);
        exp_fa = f; exp_ca = c; exp_oa = o;
        @(negedge clk);
        value_a = 17'd10;
        req_a   = 1'b1;
        @(posedge clk);
        wait_ack(1'b1, lat);
        chk("auto10_latency", 64'(lat), 64'(2 + t * 20));
        auto_change(9, "auto9");
        req_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("auto_req_ignored", 64'(ack_a), 64'd1);
        auto_change(65536, "auto65536");
        auto_change(131071, "auto131071");

        for (int i = 0; i < 20; i++) begin
            int v;
            v = (i % 2 == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 400));
            run_txn(v, "rand");
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
